// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full-subtractor cell: {b_out, diff} = a - b - b_in.
module subtractor1bit (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);
    // Two-bit difference wraps negative results so bit 1 is the borrow.
    assign {b_out, diff} = {1'b0, a} - {1'b0, b} - {1'b0, b_in};
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock through a
// single full-subtractor cell, with unsigned borrow and signed overflow flags.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    subtractor1bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .b_in (borrow),
        .diff (d),
        .b_out(bo)
    );

    // Result register after this cycle's bit enters at the MSB.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = d;
    end

    // Control: FSM state and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, serial shifting, and result/flag latching on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            borrow   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                a_msb  <= bus.a[WIDTH-1];
                b_msb  <= bus.b[WIDTH-1];
                borrow <= 1'b0;
            end else if (state == S_SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res    <= res_next;
                borrow <= bo;
                if (cnt == LAST) begin
                    diff_q   <= res_next;
                    borrow_q <= bo;
                    // Signs of operands differ and the result sign departs from the minuend.
                    ovf_q    <= (a_msb ^ b_msb) & (a_msb ^ res_next[WIDTH-1]);
                end
            end
        end
    end

    assign bus.busy       = (state == S_SHIFT);
    assign bus.done       = (state == S_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 1, 8 and 16.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor_if #(.WIDTH(1))  bus1 ();
    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: modular difference, unsigned compare, signed range test.
    function automatic void model(input int w, input int a, input int b,
                                  output int d, output bit bo, output bit ov);
        longint span, half, sa, sb, sd;
        span = 64'sd1 << w;
        half = span / 2;
        sa   = (a >= half) ? a - span : a;
        sb   = (b >= half) ? b - span : b;
        sd   = sa - sb;
        d    = int'((a - b + span) % span);
        bo   = (a < b);
        ov   = (sd < -half) || (sd > half - 1);
    endfunction

    task automatic drive(input int w, input bit s, input int a, input int b);
        case (w)
            1:       begin bus1.start  = s; bus1.a  = 1'(a);  bus1.b  = 1'(b);  end
            8:       begin bus8.start  = s; bus8.a  = 8'(a);  bus8.b  = 8'(b);  end
            default: begin bus16.start = s; bus16.a = 16'(a); bus16.b = 16'(b); end
        endcase
    endtask

    task automatic sample(input int w, output bit bsy, output bit dn,
                          output int d, output bit bo, output bit ov);
        case (w)
            1: begin
                bsy = bus1.busy; dn = bus1.done; d = int'(bus1.diff);
                bo = bus1.borrow_out; ov = bus1.ovf;
            end
            8: begin
                bsy = bus8.busy; dn = bus8.done; d = int'(bus8.diff);
                bo = bus8.borrow_out; ov = bus8.ovf;
            end
            default: begin
                bsy = bus16.busy; dn = bus16.done; d = int'(bus16.diff);
                bo = bus16.borrow_out; ov = bus16.ovf;
            end
        endcase
    endtask

    // One full operation with timing, result and hold checks.
    task automatic run_op(input int w, input int a, input int b, input bit spur,
                          input int ed, input bit eb, input bit eo);
        bit bsy, dn, bo, ov, gb, go;
        int d, gd, nbusy, ndone, dpos;
        nbusy = 0; ndone = 0; dpos = 0; gd = -1; gb = 1'b0; go = 1'b0;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, int'($urandom), int'($urandom));
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            sample(w, bsy, dn, d, bo, ov);
            if (bsy) nbusy++;
            if (dn) begin
                ndone++; dpos = k; gd = d; gb = bo; go = ov;
            end
            if (spur && k == 2) drive(w, 1'b1, 0, 0);
            if (spur && k == 3) drive(w, 1'b0, 0, 0);
        end
        check_val($sformatf("w%0d_busy_cycles", w), nbusy, w);
        check_val($sformatf("w%0d_done_count", w), ndone, 1);
        check_val($sformatf("w%0d_done_pos", w), dpos, w + 1);
        check_val($sformatf("w%0d_diff %0d-%0d", w, a, b), gd, ed);
        check_val($sformatf("w%0d_borrow %0d-%0d", w, a, b), 32'(gb), 32'(eb));
        check_val($sformatf("w%0d_ovf %0d-%0d", w, a, b), 32'(go), 32'(eo));
        check_val($sformatf("w%0d_diff_hold", w), d, ed);
    endtask

    task automatic run_model(input int w, input int a, input int b);
        int ed;
        bit eb, eo;
        model(w, a, b, ed, eb, eo);
        run_op(w, a, b, 1'b0, ed, eb, eo);
    endtask

    initial begin
        bit bsy, dn, bo, ov;
        int d, ndone, ed;
        bit eb, eo;
        int hist_a[64];
        int hist_b[64];

        rst = 1'b1;
        drive(1, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        drive(16, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        sample(8, bsy, dn, d, bo, ov);
        check_val("rst_busy", 32'(bsy), 0);
        check_val("rst_done", 32'(dn), 0);
        check_val("rst_diff", d, 0);
        check_val("rst_borrow", 32'(bo), 0);
        check_val("rst_ovf", 32'(ov), 0);
        rst = 1'b0;

        // Directed examples at WIDTH = 8.
        run_op(8, 200, 55, 1'b0, 145, 1'b0, 1'b0);
        run_op(8, 5, 10, 1'b0, 251, 1'b1, 1'b0);
        run_op(8, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        // Spurious start during SHIFT must be ignored.
        run_op(8, 200, 55, 1'b1, 145, 1'b0, 1'b0);

        // Abort mid-SHIFT with nonzero outputs present.
        run_op(8, 0, 128, 1'b0, 128, 1'b1, 1'b1);
        @(negedge clk);
        drive(8, 1'b1, 100, 3);
        @(posedge clk);
        #1 drive(8, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 sample(8, bsy, dn, d, bo, ov);
        check_val("abort_busy", 32'(bsy), 0);
        check_val("abort_done", 32'(dn), 0);
        check_val("abort_diff", d, 0);
        check_val("abort_borrow", 32'(bo), 0);
        check_val("abort_ovf", 32'(ov), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample(8, bsy, dn, d, bo, ov);
            if (dn) ndone++;
        end
        check_val("abort_no_done", ndone, 0);
        run_op(8, 9, 9, 1'b0, 0, 1'b0, 1'b0);

        // start held high with operands changing every cycle.
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            sample(8, bsy, dn, d, bo, ov);
            if (dn) begin
                ndone++;
                check_val("held_done_pos", c, 10 * ndone);
                if (c > 9) begin
                    model(8, hist_a[c-9], hist_b[c-9], ed, eb, eo);
                    check_val("held_diff", d, ed);
                    check_val("held_borrow", 32'(bo), 32'(eb));
                    check_val("held_ovf", 32'(ov), 32'(eo));
                end
            end
            hist_a[c] = int'($urandom_range(0, 255));
            hist_b[c] = int'($urandom_range(0, 255));
            drive(8, 1'b1, hist_a[c], hist_b[c]);
        end
        drive(8, 1'b0, 0, 0);
        check_val("held_done_count", ndone, 4);
        repeat (12) @(negedge clk);

        // WIDTH = 1 exhaustive, including the explicit 0-1 case.
        run_op(1, 0, 1, 1'b0, 1, 1'b1, 1'b1);
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                run_model(1, a, b);

        // Random sweeps.
        for (int i = 0; i < 6; i++)
            run_model(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        for (int i = 0; i < 15; i++)
            run_model(16, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        run_model(16, 16'h8000, 16'h0001);
        run_model(16, 0, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
